// File: rtl/alu_pkg.sv
// Shared ALU definitions for the TessiaV1 datapath.
// Operation encodings, flag bit positions and a flag packing helper.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_NOT   = 4'b0101,
        OP_SHL   = 4'b0110,
        OP_SHR   = 4'b0111,
        OP_ASR   = 4'b1000,
        OP_MUL   = 4'b1001,
        OP_CMP   = 4'b1010,
        OP_PASSB = 4'b1011
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_flags(
        input logic n,
        input logic z,
        input logic c,
        input logic v
    );
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_adder.sv
// N-bit adder/subtractor with carry-out and signed overflow.
// Subtraction is a + ~b + 1, so carry-out is the inverted borrow.
module alu_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         c,
    output logic         v
);

    logic [N-1:0] b_eff;
    logic [N:0]   full;

    assign b_eff = sub ? ~b : b;
    assign full  = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
    assign sum   = full[N-1:0];
    assign c     = full[N];
    assign v     = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);

endmodule

// File: rtl/alu.sv
// TessiaV1 ALU: combinational result/NZCV plus a one-cycle registered copy.
// Unused op codes yield zero, which naturally gives flags 4'b0100.
module alu
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ctrl,
    input  logic         en,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic [N-1:0] result_q,
    output logic [3:0]   flags_q
);

    localparam logic [N:0] NW = (N+1)'(N);

    logic [N-1:0]   add_sum;
    logic           add_c;
    logic           add_v;
    logic           add_sub;
    logic           b_zero;
    logic           b_big;
    logic [N:0]     shl_w;
    logic [N:0]     shr_w;
    logic [N:0]     asr_w;
    logic [2*N-1:0] prod;
    logic [N-1:0]   res;
    logic           c_f;
    logic           v_f;
    logic [N-1:0]   result_d;
    logic [3:0]     flags_d;

    assign add_sub = (ctrl == OP_SUB) || (ctrl == OP_CMP);

    alu_adder #(
        .N(N)
    ) u_adder (
        .a  (a),
        .b  (b),
        .sub(add_sub),
        .sum(add_sum),
        .c  (add_c),
        .v  (add_v)
    );

    // Guard bit on each shifter captures the last bit shifted out.
    assign b_zero = (b == '0);
    assign b_big  = ({1'b0, b} >= NW);
    assign shl_w  = {1'b0, a} << b;
    assign shr_w  = {a, 1'b0} >> b;
    assign asr_w  = $signed({a, 1'b0}) >>> b;
    assign prod   = {{N{1'b0}}, a} * {{N{1'b0}}, b};

    always_comb begin
        res = '0;
        c_f = 1'b0;
        v_f = 1'b0;
        case (ctrl)
            OP_ADD, OP_SUB, OP_CMP: begin
                res = add_sum;
                c_f = add_c;
                v_f = add_v;
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_SHL: begin
                if (b_zero) begin
                    res = a;
                end else if (!b_big) begin
                    res = shl_w[N-1:0];
                    c_f = shl_w[N];
                end
            end
            OP_SHR: begin
                if (b_zero) begin
                    res = a;
                end else if (!b_big) begin
                    res = shr_w[N:1];
                    c_f = shr_w[0];
                end
            end
            OP_ASR: begin
                if (b_zero) begin
                    res = a;
                end else if (b_big) begin
                    res = {N{a[N-1]}};
                end else begin
                    res = asr_w[N:1];
                    c_f = asr_w[0];
                end
            end
            OP_MUL: begin
                res = prod[N-1:0];
                c_f = |prod[2*N-1:N];
            end
            OP_PASSB: res = b;
            default:  res = '0;
        endcase
    end

    assign result = res;
    assign flags  = pack_flags(res[N-1], res == '0, c_f, v_f);

    assign result_d = en ? result : result_q;
    assign flags_d  = en ? flags : flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Randomized self-checking bench for alu (N=4) against an arithmetic model.
// Directed vectors pin both the DUT and the model to literal values.
module tb_alu;

    localparam int N = 4;
    localparam int M = 1 << N;

    logic         clk;
    logic         rst;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ctrl;
    logic         en;
    logic [N-1:0] result;
    logic [3:0]   flags;
    logic [N-1:0] result_q;
    logic [3:0]   flags_q;

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;
    logic [N+3:0] mq;

    alu #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .ctrl    (ctrl),
        .en      (en),
        .result  (result),
        .flags   (flags),
        .result_q(result_q),
        .flags_q (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N+3:0] model(input int ua, input int ub, input int op);
        int sa, sb, s, r, c, v;
        sa = (ua >= M/2) ? ua - M : ua;
        sb = (ub >= M/2) ? ub - M : ub;
        r = 0; c = 0; v = 0;
        case (op)
            0: begin
                s = ua + ub; r = s % M; c = (s >= M) ? 1 : 0;
                s = sa + sb; v = (s > M/2-1 || s < -M/2) ? 1 : 0;
            end
            1, 10: begin
                r = (ua - ub + M) % M; c = (ua >= ub) ? 1 : 0;
                s = sa - sb; v = (s > M/2-1 || s < -M/2) ? 1 : 0;
            end
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            5: r = (M - 1) - ua;
            6: if (ub == 0) r = ua;
               else if (ub < N) begin r = (ua << ub) % M; c = (ua >> (N - ub)) & 1; end
            7: if (ub == 0) r = ua;
               else if (ub < N) begin r = ua >> ub; c = (ua >> (ub - 1)) & 1; end
            8: if (ub == 0) r = ua;
               else if (ub >= N) r = (sa < 0) ? M - 1 : 0;
               else begin r = ((sa >>> ub) + M) % M; c = (ua >> (ub - 1)) & 1; end
            9: begin s = ua * ub; r = s % M; c = (s >= M) ? 1 : 0; end
            11: r = ub;
            default: r = 0;
        endcase
        return {r[N-1:0], (r >= M/2) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, c[0], v[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) mq <= '0;
        else if (en) mq <= model(int'(a), int'(b), int'(ctrl));
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [N+3:0] e;
            e = model(int'(a), int'(b), int'(ctrl));
            check("result", 32'(result), 32'(e[N+3:4]));
            check("flags", 32'(flags), 32'(e[3:0]));
            check("result_q", 32'(result_q), 32'(mq[N+3:4]));
            check("flags_q", 32'(flags_q), 32'(mq[3:0]));
        end
    end

    task automatic directed(input string name, input int op, input int av, input int bv,
                            input int er, input int ef);
        logic [N+3:0] e;
        ctrl = 4'(op); a = N'(av); b = N'(bv);
        #1;
        e = model(av, bv, op);
        check({name, "_res"}, 32'(result), 32'(er));
        check({name, "_flg"}, 32'(flags), 32'(ef));
        check({name, "_model"}, 32'(e), 32'((er << 4) | ef));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; a = '0; b = '0; ctrl = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rq", 32'(result_q), 32'd0);
        check("reset_fq", 32'(flags_q), 32'd0);
        rst = 1'b0;
        chk_on = 1'b1;

        @(posedge clk); #1;
        directed("add1", 0, 4'b0001, 4'b0001, 4'b0010, 4'b0000);
        directed("add2", 0, 4'b1111, 4'b1110, 4'b1101, 4'b1010);
        directed("add3", 0, 4'b0000, 4'b1110, 4'b1110, 4'b1000);
        directed("add4", 0, 4'b1111, 4'b1111, 4'b1110, 4'b1010);
        directed("add5", 0, 4'b0111, 4'b0001, 4'b1000, 4'b1001);
        directed("sub1", 1, 4'b0011, 4'b0011, 4'b0000, 4'b0110);
        directed("sub2", 1, 4'b0000, 4'b0001, 4'b1111, 4'b1000);
        directed("shl1", 6, 4'b1001, 4'b0001, 4'b0010, 4'b0010);
        directed("asr1", 8, 4'b1000, 4'b0101, 4'b1111, 4'b1000);
        directed("unused", 15, 4'b1010, 4'b0110, 4'b0000, 4'b0100);
        directed("shr0", 7, 4'b1011, 4'b0000, 4'b1011, 4'b1000);
        directed("mul1", 9, 4'b0101, 4'b0100, 4'b0100, 4'b0010);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            a    = N'($urandom);
            b    = N'($urandom);
            ctrl = 4'($urandom_range(0, 15));
            en   = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk); #1;
        en = 1'b1; ctrl = 4'b0000; a = 4'b0111; b = 4'b0001;
        @(posedge clk); #1;
        check("pre_rst_rq", 32'(result_q), 32'h8);
        #2 rst = 1'b1;
        #1;
        check("async_rq", 32'(result_q), 32'd0);
        check("async_fq", 32'(flags_q), 32'd0);
        @(posedge clk); #1;
        check("held_rst_rq", 32'(result_q), 32'd0);
        rst = 1'b0;
        ctrl = 4'b0000; a = 4'b1111; b = 4'b1110;
        @(posedge clk); #1;
        check("release_rq", 32'(result_q), 32'hd);
        check("release_fq", 32'(flags_q), 32'ha);
        en = 1'b0; ctrl = 4'b0001; a = 4'b0011; b = 4'b0011;
        @(posedge clk); #1;
        check("hold_rq", 32'(result_q), 32'hd);
        check("hold_fq", 32'(flags_q), 32'ha);

        @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
